// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared constants for the instruction-memory loader: loader FSM state
// encodings, word geometry and the width of the frame length field.
// Optional checksum build: IMEM_LOADER_CSUM_EN (adds the CSUM state use).
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_LEN0 = 3'd0;
    localparam state_t ST_LEN1 = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CSUM = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// byte_to_word_packer
// Collects bytes LSB-first into a 32-bit little-endian word and flags the
// byte that completes the word.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clr         synchronous restart: next byte becomes byte 0
//   byte_valid  a byte is accepted this edge
//   byte_data   the accepted byte
//   word        assembled word (lanes hold their last written byte)
//   word_done   combinational: this accepted byte is the 4th of the word
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] idx_reg;

    assign word_done = byte_valid && (idx_reg == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= '0;
        end else if (clr) begin
            idx_reg <= '0;
        end else if (byte_valid) begin
            idx_reg <= word_done ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // One register per byte lane; only the lane selected by idx captures.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (!clr && byte_valid && (idx_reg == IDX_W'(gi))) begin
                    lane_reg <= byte_data;
                end
            end

            assign word[8*gi +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Writer side of the instruction memory. Receives a framed byte stream
// (LEN_LO, LEN_HI, then 4*N data bytes, LSB-first per word), writes the
// words sequentially from address 0 and holds the pipeline in reset until
// the load completes.
// Build option: define IMEM_LOADER_CSUM_EN to require a trailing XOR
// checksum byte over all data bytes.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         restart pulse, wins over a same-edge byte
//   s_valid/s_data/s_ready  byte stream handshake
//   imem_we/imem_addr/imem_wdata  instruction-memory write port
//   cpu_rst       pipeline reset hold (released one edge after DONE)
//   done, error   sticky completion / failure flags
//   words_loaded  words written in the current load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 2**ADDR_W;

    // State entered once the data (or the empty frame) is finished.
`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t ST_TAIL = ST_CSUM;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    state_t            state_reg;
    logic              imem_we_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic              cpu_rst_reg;
    logic              done_reg;
    logic              error_reg;
    logic [ADDR_W:0]   words_loaded_reg;
    logic [LEN_W-1:0]  len_reg;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        csum_reg;
`endif

    logic              accept;
    logic              pack_valid;
    logic              word_done;
    logic [ADDR_W:0]   words_next;
    logic [LEN_W-1:0]  len_full;
    logic              len_too_big;
    logic              last_word;

    assign s_ready      = (state_reg != ST_DONE) && (state_reg != ST_ERR);
    assign accept       = s_valid && s_ready && !start;
    assign pack_valid   = accept && (state_reg == ST_DATA);
    assign words_next   = words_loaded_reg + (ADDR_W+1)'(1);
    assign len_full     = {s_data, len_reg[7:0]};
    assign len_too_big  = ({1'b0, len_full} > (LEN_W+1)'(DEPTH));
    assign last_word    = (LEN_W'(words_next) == len_reg);

    assign imem_we      = imem_we_reg;
    assign imem_addr    = imem_addr_reg;
    assign cpu_rst      = cpu_rst_reg;
    assign done         = done_reg;
    assign error        = error_reg;
    assign words_loaded = words_loaded_reg;

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start),
        .byte_valid (pack_valid),
        .byte_data  (s_data),
        .word       (imem_wdata),
        .word_done  (word_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_LEN0;
            imem_we_reg      <= 1'b0;
            imem_addr_reg    <= '0;
            cpu_rst_reg      <= 1'b1;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            words_loaded_reg <= '0;
            len_reg          <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_reg         <= '0;
`endif
        end else begin
            imem_we_reg <= 1'b0;
            if (start) begin
                state_reg        <= ST_LEN0;
                imem_addr_reg    <= '0;
                cpu_rst_reg      <= 1'b1;
                done_reg         <= 1'b0;
                error_reg        <= 1'b0;
                words_loaded_reg <= '0;
                len_reg          <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                csum_reg         <= '0;
`endif
            end else begin
                // Flags follow the terminal state by one edge so the final
                // write strobe lands while the pipeline is still held.
                if (state_reg == ST_DONE) begin
                    done_reg    <= 1'b1;
                    cpu_rst_reg <= 1'b0;
                end
                if (state_reg == ST_ERR) begin
                    error_reg <= 1'b1;
                end

                // Step past the address just written; saturate so a full
                // DEPTH load never wraps back to 0.
                if (imem_we_reg && (imem_addr_reg != ADDR_W'(DEPTH - 1))) begin
                    imem_addr_reg <= imem_addr_reg + ADDR_W'(1);
                end

                if (accept) begin
                    case (state_reg)
                        ST_LEN0: begin
                            len_reg[7:0] <= s_data;
                            state_reg    <= ST_LEN1;
                        end
                        ST_LEN1: begin
                            len_reg[LEN_W-1:8] <= s_data;
                            if (len_too_big) begin
                                state_reg <= ST_ERR;
                            end else if (len_full == '0) begin
                                state_reg <= ST_TAIL;
                            end else begin
                                state_reg <= ST_DATA;
                            end
                        end
                        ST_DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
                            csum_reg <= csum_reg ^ s_data;
`endif
                            if (word_done) begin
                                imem_we_reg      <= 1'b1;
                                imem_addr_reg    <= words_loaded_reg[ADDR_W-1:0];
                                words_loaded_reg <= words_next;
                                if (last_word) begin
                                    state_reg <= ST_TAIL;
                                end
                            end
                        end
`ifdef IMEM_LOADER_CSUM_EN
                        ST_CSUM: begin
                            state_reg <= (s_data == csum_reg) ? ST_DONE : ST_ERR;
                        end
`endif
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(32'(imem_addr));
            wr_data_q.push_back(imem_wdata);
            $display("write addr=%0d data=0x%08h", imem_addr, imem_wdata);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) @(posedge clk);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic two_word_load(input int max_gap);
        logic [7:0] bytes [10];
        bytes = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_start();
        check_val("tw_start_cpu_rst", 32'(cpu_rst), 32'd1);
        for (int i = 0; i < 10; i++) send_byte(bytes[i], max_gap);
        check_val("tw_last_we", 32'(imem_we), 32'd1);
        check_val("tw_last_addr", 32'(imem_addr), 32'd1);
        check_val("tw_done_early", 32'(done), 32'd0);
        check_val("tw_cpu_rst_held", 32'(cpu_rst), 32'd1);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h2A, max_gap);
`endif
        @(posedge clk);
        #1;
        check_val("tw_done", 32'(done), 32'd1);
        check_val("tw_cpu_rst", 32'(cpu_rst), 32'd0);
        check_val("tw_error", 32'(error), 32'd0);
        check_val("tw_words", 32'(words_loaded), 32'd2);
        check_val("tw_s_ready", 32'(s_ready), 32'd0);
        check_val("tw_nwrites", 32'(wr_addr_q.size()), 32'd2);
        check_val("tw_addr0", wr_addr_q[0], 32'd0);
        check_val("tw_data0", wr_data_q[0], 32'h12345678);
        check_val("tw_addr1", wr_addr_q[1], 32'd1);
        check_val("tw_data1", wr_data_q[1], 32'hDEADBEEF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check_val("rst_s_ready", 32'(s_ready), 32'd1);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        check_val("rst_we", 32'(imem_we), 32'd0);
        check_val("rst_words", 32'(words_loaded), 32'd0);
        check_val("rst_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back, then with random valid gaps.
        two_word_load(0);
        two_word_load(3);

        // Bytes presented in DONE are not consumed.
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b0;
        check_val("done_ignore_words", 32'(words_loaded), 32'd2);
        check_val("done_ignore_done", 32'(done), 32'd1);

        // Zero-length frame.
        do_start();
        check_val("zl_done_cleared", 32'(done), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h00, 0);
`endif
        @(posedge clk);
        #1;
        check_val("zl_done", 32'(done), 32'd1);
        check_val("zl_cpu_rst", 32'(cpu_rst), 32'd0);
        check_val("zl_nwrites", 32'(wr_addr_q.size()), 32'd0);
        check_val("zl_words", 32'(words_loaded), 32'd0);

        // Overflow: N = 65 > DEPTH.
        do_start();
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        check_val("ov_s_ready", 32'(s_ready), 32'd0);
        check_val("ov_error_early", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        check_val("ov_error", 32'(error), 32'd1);
        check_val("ov_cpu_rst", 32'(cpu_rst), 32'd1);
        check_val("ov_done", 32'(done), 32'd0);
        check_val("ov_nwrites", 32'(wr_addr_q.size()), 32'd0);

        // N == DEPTH: word i = {i,i,i,i}; per-word XOR is 0 so checksum is 0.
        do_start();
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        for (int w = 0; w < 64; w++) begin
            for (int b = 0; b < 4; b++) send_byte(8'(w), 0);
        end
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h00, 0);
`endif
        @(posedge clk);
        #1;
        check_val("full_done", 32'(done), 32'd1);
        check_val("full_error", 32'(error), 32'd0);
        check_val("full_words", 32'(words_loaded), 32'd64);
        check_val("full_nwrites", 32'(wr_addr_q.size()), 32'd64);
        check_val("full_addr_last", wr_addr_q[63], 32'd63);
        check_val("full_data_last", wr_data_q[63], 32'h3F3F3F3F);
        check_val("full_addr_mid", wr_addr_q[10], 32'd10);
        check_val("full_data_mid", wr_data_q[10], 32'h0A0A0A0A);

        // Restart mid-frame after 5 data bytes; same-edge byte must be dropped.
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'hEF, 0);
        @(negedge clk);
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        @(posedge clk);
        #1;
        start   = 1'b0;
        s_valid = 1'b0;
        check_val("rs_words_clr", 32'(words_loaded), 32'd0);
        check_val("rs_addr_clr", 32'(imem_addr), 32'd0);
        check_val("rs_cpu_rst", 32'(cpu_rst), 32'd1);
        check_val("rs_done", 32'(done), 32'd0);
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h44, 0);
`endif
        @(posedge clk);
        #1;
        check_val("rs_done_final", 32'(done), 32'd1);
        check_val("rs_words", 32'(words_loaded), 32'd1);
        check_val("rs_nwrites", 32'(wr_addr_q.size()), 32'd1);
        check_val("rs_addr0", wr_addr_q[0], 32'd0);
        check_val("rs_data0", wr_data_q[0], 32'h11223344);

`ifdef IMEM_LOADER_CSUM_EN
        // Checksum good / bad on 01 00 11 22 33 44.
        for (int k = 0; k < 2; k++) begin
            do_start();
            send_byte(8'h01, 0);
            send_byte(8'h00, 0);
            send_byte(8'h11, 0);
            send_byte(8'h22, 0);
            send_byte(8'h33, 0);
            send_byte(8'h44, 0);
            send_byte((k == 0) ? 8'h44 : 8'h45, 0);
            @(posedge clk);
            #1;
            check_val("cs_done", 32'(done), (k == 0) ? 32'd1 : 32'd0);
            check_val("cs_error", 32'(error), (k == 0) ? 32'd0 : 32'd1);
            check_val("cs_cpu_rst", 32'(cpu_rst), (k == 0) ? 32'd0 : 32'd1);
            check_val("cs_data", wr_data_q[0], 32'h44332211);
        end
`endif

        // Asynchronous reset right after a word completes: strobe must vanish.
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        check_val("ar_we_before", 32'(imem_we), 32'd1);
        rst = 1'b1;
        #1;
        check_val("ar_we", 32'(imem_we), 32'd0);
        check_val("ar_words", 32'(words_loaded), 32'd0);
        check_val("ar_cpu_rst", 32'(cpu_rst), 32'd1);
        check_val("ar_s_ready", 32'(s_ready), 32'd1);
        check_val("ar_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that Fetch reads: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially into instruction memory from address 0.
- Holds the pipeline in reset (`cpu_rst`) until a load completes, then releases it so Fetch starts from a freshly written program.
- Sits beside the pipeline top; its write port feeds the instruction-memory write side.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; restarts loading from any state
- s_valid  input  1  byte-stream valid
- s_data  input  8  byte-stream data
- s_ready  output  1  loader can accept a byte
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  word address of the write
- imem_wdata  output  32  word being written
- cpu_rst  output  1  pipeline reset hold, active-high
- done  output  1  load completed successfully (sticky)
- error  output  1  load failed (sticky)
- words_loaded  output  ADDR_W+1  count of words written in the current load

Behaviour:
- Clock and reset (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.
- A byte transfers on a rising edge when `s_valid && s_ready`.
- Reset values: state LEN0; `cpu_rst`=1; `s_ready`=1; `imem_we`=0; `imem_addr`=0; `imem_wdata`=0; `done`=0; `error`=0; `words_loaded`=0; byte index=0; length=0.
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes, LSB-first per word.
- States:
  - LEN0: accept LEN_LO → LEN1.
  - LEN1: accept LEN_HI, then branch:
    - N > DEPTH → ERR.
    - N == 0 → DONE (or CSUM if enabled).
    - Otherwise → DATA.
  - DATA: shift each accepted byte into `imem_wdata[8*idx +: 8]`. On the 4th byte (idx==3), at the same edge:
    - set `imem_we`=1 for exactly the following cycle, with `imem_addr` = words_loaded;
    - increment `words_loaded`; reset idx to 0.
    - If this was word N → DONE (or CSUM). `imem_addr` advances after the pulse.
  - DONE / ERR: `s_ready`=0. Input bytes are ignored, not consumed.
- `done` / `error` are set, and `cpu_rst` cleared (DONE only), one edge after the state enters DONE/ERR. This guarantees the last `imem_we` completes while the pipeline is still held. `cpu_rst` stays 1 in ERR.
- Gaps (`s_valid`=0) at any point stall without side effects. No timeout.
- `start` (any state, including mid-frame) has priority over a same-edge byte transfer: it drops that byte and returns to LEN0. It also:
  - clears `done`, `error`, `words_loaded`, idx and `imem_addr`;
  - sets `cpu_rst`=1.
  - Memory contents already written are not erased.
- N == DEPTH is legal: the last write goes to address DEPTH-1; `imem_addr` wrap is never exercised.
- `rst` asserted mid-load: immediately returns to reset values; no `imem_we` is issued.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- Enabled:
  - A running XOR of all data bytes (length bytes excluded) is kept, cleared on `start`/`rst`.
  - After word N (or after LEN1 when N==0) the state goes to CSUM and accepts one trailing byte.
  - Byte equals XOR → DONE; otherwise → ERR.
- Disabled: no CSUM state, no checksum register; the frame ends after the last data byte.

Decomposition:
- Shared package `imem_loader_pkg`:
  - state enum (LEN0, LEN1, DATA, CSUM, DONE, ERR);
  - `BYTES_PER_WORD`=4;
  - `LEN_W`=16.
- One natural sub-module: `byte_to_word_packer`, which handles byte index, shift into word, and word-complete pulse. The FSM, counters and handshake stay in the top.

Test Plan:
- Reset: hold `rst` → `cpu_rst`=1, `s_ready`=1, `done`=0, `error`=0, `imem_we`=0, `words_loaded`=0.
- Two-word load, stream 02 00 | 78 56 34 12 | EF BE AD DE → `imem_we` pulses with addr0=0x12345678 and addr1=0xDEADBEEF. `done`=1 and `cpu_rst`=0 one edge after the second write cycle; `words_loaded`=2.
- Length zero, stream 00 00 → no `imem_we`; `done`=1; `cpu_rst`=0. With CSUM enabled, a trailing 00 is also needed.
- Overflow with ADDR_W=6, stream 41 00 (N=65) → no writes; `error`=1; `cpu_rst` stays 1; `s_ready`=0.
- Stall and restart:
  - Random `s_valid` gaps in the two-word load → identical writes.
  - `start` after 5 data bytes, then a fresh one-word frame → one write at addr 0, `words_loaded`=1, `done`=1.
- CSUM (macro on), one-word frame 01 00 11 22 33 44:
  - trailing 44 (0x11^0x22^0x33^0x44) → `done`=1;
  - trailing 45 → `error`=1 and `cpu_rst` stays 1.
